shared_ram_arbiter: RTL and testbench
=====================================

Name: shared_ram_arbiter

Overview:
Round-robin arbiter and access sequencer that lets NUM_REQ peripherals share one single-port RAM in the SoC. Each peripheral has a request port: req, we, address and write data. The block picks one winner, drives the RAM read/write strobes for exactly one cycle, acknowledges the winner with a one-cycle grant, and returns read data tagged to the winner. It sits between the peripheral bus masters and the shared RAM's address/data_in/data_out/read/write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request, level
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
rdata_valid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
rdata  out  DATA_W  read data, valid while any rdata_valid bit is high
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_read
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- All outputs are registered. While rst_n=0, every output is 0, state=IDLE and rr_ptr=NUM_REQ-1.
- States:
  - IDLE: if req!=0, select a winner, latch its we/addr/wdata and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: lasts exactly 1 cycle.
    - ram_addr and ram_wdata carry the latched values.
    - ram_write=we or ram_read=!we, exactly one of them.
    - gnt[winner]=1.
    - Next state: write -> IDLE; read -> RDATA.
  - RDATA: lasts 1 cycle. Capture ram_rdata into rdata and pulse rdata_valid[winner] in the following cycle. Next state: IDLE.
- Timing, with the request sampled at edge E:
  - gnt and the strobe are visible after edge E+1.
  - For a read, rdata/rdata_valid are visible after edge E+3.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
  - Arbitration happens only in IDLE.
- Round robin:
  - Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. The first asserted req wins.
  - rr_ptr updates to the winner index when the winner is latched.
  - After reset, requester 0 has top priority.
- Requester protocol:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop req (or present the next request) from the cycle after gnt.
  - Dropping req before gnt is a protocol violation. A latched operation still completes.
- Strobe rules:
  - ram_read and ram_write are never high together.
  - Each is high for exactly one cycle per granted operation.
  - ram_addr and ram_wdata hold their last values when no strobe is active.
- rdata holds its last captured value between reads. Only rdata_valid qualifies it.
- Simultaneous requests: resolved purely by round robin. Non-winners keep req high and win in later IDLE cycles; no request is lost.
- Reset mid-operation:
  - Asserting rst_n aborts immediately and clears strobes, gnt and rdata_valid asynchronously.
  - A pending read returns no rdata_valid.
  - After release the block starts in IDLE with rr_ptr=NUM_REQ-1.

Test Plan:
1. Single write: req[1]=1, we=1, addr=0x10, wdata=0xBB held until gnt.
   -> One cycle with ram_write=1, ram_addr=0x10, ram_wdata=0xBB and gnt=4'b0010, one edge after sampling. busy high for 1 cycle. No ram_read.
2. Write then read-back, against a RAM model:
   - req[0] writes 0xAA to 0x00, then req[2] reads 0x00.
   - -> For the read: gnt[2] and ram_read=1 for 1 cycle, then rdata_valid=4'b0100 with rdata=0xAA three edges after its request was sampled.
3. Four simultaneous writes: addresses 0x00/0x10/0x20/0x30, data 0xAA/0xBB/0xCC/0xDD.
   - -> Grants in order 0,1,2,3, each 2 cycles apart.
   - -> A subsequent read of each address returns the matching byte.
4. Fairness: req[0] and req[3] held continuously, each re-requesting after gnt.
   -> Grants alternate 0,3,0,3 over at least 8 operations. No back-to-back grant to the same requester while the other waits.
5. Reset mid-read: drop rst_n while in RDATA.
   - -> All outputs 0 immediately; no rdata_valid pulse.
   - -> After release with req[0] and req[1] both high, gnt[0] comes first.
6. Protocol checks, throughout all tests: assertions that gnt and rdata_valid are one-hot or zero, ram_read and ram_write are never both high, and busy equals (state!=IDLE).

Source files
------------

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter and access sequencer that lets NUM_REQ peripherals share
// one single-port RAM: one winner per operation, one-cycle strobes, tagged read data.
module shared_ram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rdata_valid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_read,
  output logic                      ram_write,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               rd_pending;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  // Search starts just after the last winner, so the last winner is served last.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] sel;
    logic             found;
    found = 1'b0;
    sel   = ptr;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    {pick_found, pick_idx} = rr_pick(req, rr_ptr);
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      // NOTE: datapath latches are reset too; they are few and it keeps outputs clean at reset.
      winner      <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rd_pending  <= 1'b0;
      gnt         <= '0;
      rdata_valid <= '0;
      rdata       <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gnt         <= '0;
      rdata_valid <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      rd_pending  <= 1'b0;

      // RAM data arrives one cycle after the read strobe; capture overlaps the next IDLE.
      if (rd_pending) begin
        rdata       <= ram_rdata;
        rdata_valid <= onehot(winner);
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            winner    <= pick_idx;
            rr_ptr    <= pick_idx;
            lat_we    <= req_we[pick_idx];
            lat_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            state     <= ACCESS;
            busy      <= 1'b1;
          end else begin
            busy      <= 1'b0;
          end
        end
        ACCESS: begin
          ram_addr  <= lat_addr;
          ram_wdata <= lat_wdata;
          ram_write <= lat_we;
          ram_read  <= !lat_we;
          gnt       <= onehot(winner);
          state     <= lat_we ? IDLE : RDATA;
          busy      <= !lat_we;
        end
        RDATA: begin
          rd_pending <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench for shared_ram_arbiter: expected grants and read returns are
// queued at stimulus time and compared as the DUT produces them.
module tb_shared_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rdata_valid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_read;
  logic            ram_write;
  logic [DW-1:0]   ram_rdata;
  logic            busy;

  shared_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rdata_valid(rdata_valid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read),
    .ram_write(ram_write), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM behind the arbiter.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata     <= mem[ram_addr];
  end

  typedef struct {
    int           idx;
    bit           we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int           due;
  } exp_t;

  exp_t          gnt_q[$];
  exp_t          rd_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [256];
  int            cnt [N];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pending_reqs();
    int s = 0;
    for (int i = 0; i < N; i++) s += cnt[i];
    return s;
  endfunction

  function automatic logic [63:0] all_outputs();
    return {29'd0, gnt, rdata_valid, rdata, ram_addr, ram_wdata, ram_read, ram_write, busy};
  endfunction

  // Requester side: hold the request until gnt, re-request while operations remain.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) req[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_onehot0", $onehot0(gnt), 1'b1);
      check("rdv_onehot0", $onehot0(rdata_valid), 1'b1);
      check("strobe_excl", ram_read & ram_write, 1'b0);
      check("busy_state", busy, dut.state != 2'd0);
      if (gnt != '0) begin
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", gnt, 0);
        end else begin
          mon_e = gnt_q.pop_front();
          check("gnt_idx", gnt, N'(1) << mon_e.idx);
          check("ram_write", ram_write, mon_e.we);
          check("ram_read", ram_read, !mon_e.we);
          check("ram_addr", ram_addr, mon_e.addr);
          if (mon_e.we) check("ram_wdata", ram_wdata, mon_e.data);
          if (mon_e.due >= 0) check("gnt_time", cyc, mon_e.due);
          if (!mon_e.we) begin
            mon_e.due = cyc + 2;
            rd_q.push_back(mon_e);
          end
        end
      end else begin
        check("strobe_no_gnt", {ram_read, ram_write}, 2'b00);
      end
      if (rdata_valid != '0) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rdv", rdata_valid, 0);
        end else begin
          mon_e = rd_q.pop_front();
          check("rdv_idx", rdata_valid, N'(1) << mon_e.idx);
          check("rdata", rdata, mon_e.data);
          check("rdv_time", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic start_req(input int i, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int n);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = addr;
    req_wdata[i*DW +: DW]  = wdata;
    cnt[i]                 = n;
    req[i]                 = 1'b1;
  endtask

  task automatic expect_op(input int i, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int due);
    exp_t e;
    e.idx  = i;
    e.we   = we;
    e.addr = addr;
    e.due  = due;
    if (we) begin
      e.data        = wdata;
      ref_mem[addr] = wdata;
    end else begin
      e.data = ref_mem[addr];
    end
    gnt_q.push_back(e);
  endtask

  task automatic issue(input int i, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int due);
    start_req(i, we, addr, wdata, 1);
    expect_op(i, we, addr, wdata, due);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && rd_q.size() == 0 && pending_reqs() == 0 && !busy) break;
    end
    if (k == 200) check({tag, "_timeout"}, gnt_q.size() + rd_q.size() + pending_reqs(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    gnt_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    check("reset_rr_ptr", dut.rr_ptr, N - 1);
    check("reset_state", dut.state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int n_busy;
    int n_rd;
    int n_rdv;
    bit hit;
    rst_n     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    // Single write from requester 1.
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    issue(1, 1'b1, 8'h10, 8'hBB, c + 2);
    n_busy = 0;
    n_rd   = 0;
    repeat (6) begin
      @(negedge clk);
      n_busy += int'(busy);
      n_rd   += int'(ram_read);
    end
    check("t1_busy_cycles", n_busy, 1);
    check("t1_no_read", n_rd, 0);
    wait_done("t1");

    // Write then read back through a different requester.
    do_reset();
    @(posedge clk); #1;
    issue(0, 1'b1, 8'h00, 8'hAA, cyc + 2);
    wait_done("t2w");
    @(posedge clk); #1;
    issue(2, 1'b0, 8'h00, 8'h00, cyc + 2);
    wait_done("t2r");

    // Four simultaneous writes, then four simultaneous reads.
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    for (int i = 0; i < N; i++) start_req(i, 1'b1, 8'(i * 16), 8'(8'hAA + i * 8'h11), 1);
    for (int i = 0; i < N; i++) expect_op(i, 1'b1, 8'(i * 16), 8'(8'hAA + i * 8'h11), c + 2 + 2 * i);
    wait_done("t3w");
    @(posedge clk); #1;
    c = cyc;
    for (int i = 0; i < N; i++) start_req(i, 1'b0, 8'(i * 16), 8'h00, 1);
    for (int i = 0; i < N; i++) expect_op(i, 1'b0, 8'(i * 16), 8'h00, c + 2 + 3 * i);
    wait_done("t3r");

    // Fairness between requesters 0 and 3 under continuous load.
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    start_req(0, 1'b1, 8'h80, 8'h01, 4);
    start_req(3, 1'b1, 8'h83, 8'h03, 4);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) expect_op(0, 1'b1, 8'h80, 8'h01, c + 2 + 2 * k);
      else            expect_op(3, 1'b1, 8'h83, 8'h03, c + 2 + 2 * k);
    end
    wait_done("t4");

    // Reset in the middle of a read.
    do_reset();
    @(posedge clk); #1;
    issue(0, 1'b1, 8'h42, 8'h5A, cyc + 2);
    wait_done("t5w");
    @(posedge clk); #1;
    issue(0, 1'b0, 8'h42, 8'h00, cyc + 2);
    wait_done("t5r");
    @(posedge clk); #1;
    start_req(0, 1'b0, 8'h42, 8'h00, 1);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge clk); #2;
      hit = gnt[0];
    end
    check("t5_read_granted", hit, 1'b1);
    check("t5_in_rdata", dut.state, 2'd2);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", all_outputs(), 0);
    req = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    gnt_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rr_ptr", dut.rr_ptr, N - 1);
    n_rdv = 0;
    repeat (4) begin
      @(negedge clk);
      n_rdv += int'(rdata_valid != '0);
    end
    check("t5_no_rdv", n_rdv, 0);
    @(posedge clk); #1;
    c = cyc;
    start_req(0, 1'b1, 8'h50, 8'h11, 1);
    start_req(1, 1'b1, 8'h51, 8'h22, 1);
    expect_op(0, 1'b1, 8'h50, 8'h11, c + 2);
    expect_op(1, 1'b1, 8'h51, 8'h22, c + 4);
    wait_done("t5post");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
